alu_seq: RTL and testbench

Sequential ALU execution stage that consumes the 4-bit operation code produced by the ALU control decoder together with two 32-bit operands. It completes arithmetic and logical operations in one cycle and shifts iteratively, one bit per cycle, under a start/busy/done handshake. Result and zero flag are registered and held for writeback and branch logic.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_shift_iter.sv | 56 +++++
 rtl/alu_seq.sv | 131 +++++++++++++
 tb/tb_alu_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and shift direction for the ALU execute stage
package alu_seq_pkg;

  localparam int OP_WIDTH = 4;

  // Opcodes produced by the ALU control decoder.
  localparam logic [OP_WIDTH-1:0] ALU_ADD = 4'b0000;
  localparam logic [OP_WIDTH-1:0] ALU_SUB = 4'b0001;
  localparam logic [OP_WIDTH-1:0] ALU_LUI = 4'b1000;
  localparam logic [OP_WIDTH-1:0] ALU_OR  = 4'b1001;
  localparam logic [OP_WIDTH-1:0] ALU_AND = 4'b1010;
  localparam logic [OP_WIDTH-1:0] ALU_XOR = 4'b1011;
  localparam logic [OP_WIDTH-1:0] ALU_SLL = 4'b1100;
  localparam logic [OP_WIDTH-1:0] ALU_SRL = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  function automatic logic op_is_shift(input logic [OP_WIDTH-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - one-bit-per-cycle shifter owning the accumulator and remaining-count
module alu_shift_iter
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  shift_dir_e             dir_i,
  input  logic [DATA_WIDTH-1:0]  value_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   finished_o,
  output logic [DATA_WIDTH-1:0]  value_o
);

  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  shift_dir_e             dir_q, dir_d;
  logic [DATA_WIDTH-1:0]  acc_shifted;

  assign acc_shifted = (dir_q == SHIFT_RIGHT) ? (acc_q >> 1) : (acc_q << 1);

  // The step that takes the count from 1 to 0 is the last one; its result is
  // presented combinationally so the owner can capture it on that same edge.
  assign finished_o = (cnt_q == SHAMT_WIDTH'(1));
  assign value_o    = acc_shifted;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (load_i) begin
      acc_d = value_i;
      cnt_d = shamt_i;
      dir_d = dir_i;
    end else if (cnt_q != '0) begin
      acc_d = acc_shifted;
      cnt_d = cnt_q - SHAMT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      dir_q <= SHIFT_LEFT;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU execute stage with start/busy/done handshake
// ALU_SHIFT_FAST_EN: use a single-cycle barrel shifter instead of the iterative shifter.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [OP_WIDTH-1:0]   ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;
  logic [DATA_WIDTH-1:0]  op_res;
  logic [SHAMT_WIDTH-1:0] shamt;

  assign shamt = B_i[SHAMT_WIDTH-1:0];

  // Single-cycle result; iterative shifts only use this path when shamt is 0.
  always_comb begin
    op_res = '0;
    case (ALU_Operation_i)
      ALU_ADD: op_res = A_i + B_i;
      ALU_SUB: op_res = A_i - B_i;
      ALU_LUI: op_res = B_i;
      ALU_OR:  op_res = A_i | B_i;
      ALU_AND: op_res = A_i & B_i;
      ALU_XOR: op_res = A_i ^ B_i;
`ifdef ALU_SHIFT_FAST_EN
      ALU_SLL: op_res = A_i << shamt;
      ALU_SRL: op_res = A_i >> shamt;
`else
      ALU_SLL, ALU_SRL: op_res = A_i;
`endif
      default: op_res = '0;
    endcase
  end

`ifndef ALU_SHIFT_FAST_EN
  logic                  shift_load;
  logic                  shift_finished;
  logic [DATA_WIDTH-1:0] shift_value;
  shift_dir_e            shift_dir;

  assign shift_dir = (ALU_Operation_i == ALU_SRL) ? SHIFT_RIGHT : SHIFT_LEFT;

  alu_shift_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load_i    (shift_load),
    .dir_i     (shift_dir),
    .value_i   (A_i),
    .shamt_i   (shamt),
    .finished_o(shift_finished),
    .value_o   (shift_value)
  );
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifndef ALU_SHIFT_FAST_EN
    shift_load = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d  = ST_DONE;
          result_d = op_res;
`ifndef ALU_SHIFT_FAST_EN
          if (op_is_shift(ALU_Operation_i) && (shamt != '0)) begin
            state_d    = ST_SHIFT;
            result_d   = result_q;
            shift_load = 1'b1;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
`ifndef ALU_SHIFT_FAST_EN
        // start_i is deliberately not looked at here: requests during a shift are dropped.
        if (shift_finished) begin
          state_d  = ST_DONE;
          result_d = shift_value;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

`ifdef ALU_SHIFT_FAST_EN
  assign busy_o = 1'b0;
`else
  assign busy_o = (state_q == ST_SHIFT);
`endif
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  op = 4'b0000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy_o, done_o, zero_o;
  logic [31:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ALU_SHIFT_FAST_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  alu_seq dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .ALU_Operation_i(op),
    .A_i            (a),
    .B_i            (b),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .result_o       (result_o),
    .zero_o         (zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    start_i = 1'b1;
    op = o;
    a = av;
    b = bv;
  endtask

  // Runs from cycle 0 (start already driven) until done_o; returns done cycle and busy count.
  task automatic wait_done(output int done_cyc, output int busy_cnt, input logic pulse_c5);
    done_cyc = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      start_i = 1'b0;
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cyc = c;
        break;
      end
      if (c == 5 && pulse_c5) drive(4'b0000, 32'h5, 32'h3);
      if (c == 10) check("shift_result_held", result_o, 32'h0);
    end
  endtask

  int dc, bc, pulses;

  initial begin
    step();
    step();
    check("rst_result", result_o, 32'h0);
    check("rst_zero", {31'b0, zero_o}, 32'h1);
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    check("rst_done", {31'b0, done_o}, 32'h0);
    reset = 1'b0;

    drive(4'b0000, 32'h5, 32'h3);
    step();
    check("add_done", {31'b0, done_o}, 32'h1);
    check("add_result", result_o, 32'h8);
    drive(4'b0001, 32'h5, 32'h3);
    step();
    check("sub_b2b_done", {31'b0, done_o}, 32'h1);
    check("sub_b2b_result", result_o, 32'h2);
    check("sub_b2b_zero", {31'b0, zero_o}, 32'h0);
    start_i = 1'b0;
    step();
    check("idle_done", {31'b0, done_o}, 32'h0);
    check("idle_held", result_o, 32'h2);

    drive(4'b0001, 32'h1234_5678, 32'h1234_5678);
    step();
    check("sub0_result", result_o, 32'h0);
    check("sub0_zero", {31'b0, zero_o}, 32'h1);
    drive(4'b1000, 32'h1111_1111, 32'hABCD_0000);
    step();
    check("lui_result", result_o, 32'hABCD_0000);
    drive(4'b1001, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    step();
    check("or_result", result_o, 32'hFFF0_0FFF);
    drive(4'b1010, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    step();
    check("and_result", result_o, 32'h00F0_000F);
    drive(4'b1011, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    step();
    check("xor_result", result_o, 32'hFF00_0FF0);
    drive(4'b0111, 32'h5, 32'h3);
    step();
    check("unk_done", {31'b0, done_o}, 32'h1);
    check("unk_result", result_o, 32'h0);
    check("unk_zero", {31'b0, zero_o}, 32'h1);
    start_i = 1'b0;
    step();

    drive(4'b1100, 32'h1, 32'h1F);
    wait_done(dc, bc, FAST == 0);
    check("sll31_done_cycle", dc, FAST ? 32'd1 : 32'd32);
    check("sll31_busy_cycles", bc, FAST ? 32'd0 : 32'd31);
    check("sll31_result", result_o, 32'h8000_0000);
    start_i = 1'b0;
    step();
    check("sll31_no_extra_done", {31'b0, done_o}, 32'h0);
    check("sll31_held", result_o, 32'h8000_0000);

    drive(4'b1101, 32'hF000_0000, 32'h0);
    step();
    check("srl0_done", {31'b0, done_o}, 32'h1);
    check("srl0_result", result_o, 32'hF000_0000);
    start_i = 1'b0;
    step();
    drive(4'b1101, 32'hF000_0000, 32'h4);
    wait_done(dc, bc, 1'b0);
    check("srl4_done_cycle", dc, FAST ? 32'd1 : 32'd5);
    check("srl4_result", result_o, 32'h0F00_0000);
    start_i = 1'b0;
    step();

    drive(4'b1100, 32'h1, 32'd20);
    for (int c = 1; c <= 8; c++) begin
      step();
      start_i = 1'b0;
      if (c == 1) begin
        check("sll20_c1_done", {31'b0, done_o}, FAST ? 32'h1 : 32'h0);
        check("sll20_c1_busy", {31'b0, busy_o}, FAST ? 32'h0 : 32'h1);
        if (FAST) check("sll20_fast_result", result_o, 32'h0010_0000);
      end
    end
    reset = 1'b1;
    drive(4'b0000, 32'h5, 32'h3);
    step();
    reset = 1'b0;
    start_i = 1'b0;
    check("midrst_result", result_o, 32'h0);
    check("midrst_zero", {31'b0, zero_o}, 32'h1);
    check("midrst_busy", {31'b0, busy_o}, 32'h0);
    check("midrst_done", {31'b0, done_o}, 32'h0);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (done_o) pulses++;
    end
    check("midrst_no_done_pulse", pulses, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
